// File: rtl/memwb_stage_if.sv
// memwb_stage_if: MEM/WB pipeline-register bus.
// The MEM stage drives through the master modport and memwb_stage consumes it
// through the slave modport. With MEMWB_RETIRE_CNT_EN defined, the bus also
// carries retire_count.
interface memwb_stage_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned CNT_W   = 16
) ();

  // MEM-stage side
  logic               valid_in;
  logic               stall;
  logic               flush;
  logic               regwrite_in;
  logic               mem_to_reg_in;
  logic [1:0]         load_size_in;
  logic               load_signed_in;
  logic [DATA_W-1:0]  read_ram_data_in;
  logic [DATA_W-1:0]  alu_result_in;
  logic [RADDR_W-1:0] rd_in;

  // Write-back / forwarding side
  logic               wb_we;
  logic [RADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_valid;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0]   retire_count;
`else
  // Without the counter, CNT_W only keeps the parameter list uniform.
  logic               unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

  modport master (
    output valid_in, stall, flush, regwrite_in, mem_to_reg_in,
    output load_size_in, load_signed_in, read_ram_data_in, alu_result_in, rd_in,
    input  wb_we, wb_rd, wb_data, wb_valid
`ifdef MEMWB_RETIRE_CNT_EN
    , input retire_count
`endif
  );

  modport slave (
    input  valid_in, stall, flush, regwrite_in, mem_to_reg_in,
    input  load_size_in, load_signed_in, read_ram_data_in, alu_result_in, rd_in,
    output wb_we, wb_rd, wb_data, wb_valid
`ifdef MEMWB_RETIRE_CNT_EN
    , output retire_count
`endif
  );

endinterface

// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB pipeline register with stall, flush and valid tracking.
// It also performs load-size and sign extension on the write-back path and
// serves as the registered forwarding tap for the EX-stage bypass.
// Optional feature macro: MEMWB_RETIRE_CNT_EN adds the retire_count counter.
// wb_data and wb_we are decoded only from registered state, so no input
// reaches an output combinationally.
module memwb_stage #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RADDR_W  = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  memwb_stage_if.slave  mw
);

  // Width of a half-word load; on an 8-bit datapath a half is the full word.
  localparam int unsigned HALF_W      = (DATA_W < 16) ? DATA_W : 16;
  localparam logic        SUPPRESS_R0 = (ZERO_REG != 0);

  // Stage registers
  logic               r_valid;
  logic               r_regwrite;
  logic               r_mem_to_reg;
  logic [1:0]         r_load_size;
  logic               r_load_signed;
  logic [DATA_W-1:0]  r_ram;
  logic [DATA_W-1:0]  r_alu;
  logic [RADDR_W-1:0] r_rd;

  // Write-back decode
  logic               w_byte_fill;
  logic               w_half_fill;
  logic [DATA_W-1:0]  w_byte_ext;
  logic [DATA_W-1:0]  w_half_ext;
  logic [DATA_W-1:0]  w_load_data;
  logic [DATA_W-1:0]  w_wb_data;
  logic               w_rd_suppressed;
  logic               w_wb_we;

  // Control fields: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_regwrite    <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_load_size   <= 2'd0;
      r_load_signed <= 1'b0;
      r_rd          <= '0;
    end else if (mw.flush) begin
      r_valid       <= 1'b0;
      r_regwrite    <= 1'b0;
      r_mem_to_reg  <= mw.mem_to_reg_in;
      r_load_size   <= mw.load_size_in;
      r_load_signed <= mw.load_signed_in;
      r_rd          <= mw.rd_in;
    end else if (!mw.stall) begin
      r_valid       <= mw.valid_in;
      r_regwrite    <= mw.regwrite_in;
      r_mem_to_reg  <= mw.mem_to_reg_in;
      r_load_size   <= mw.load_size_in;
      r_load_signed <= mw.load_signed_in;
      r_rd          <= mw.rd_in;
    end
  end

  // Data fields: captured on flush too, since a bubble's data is never used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram <= '0;
      r_alu <= '0;
    end else if (mw.flush || !mw.stall) begin
      r_ram <= mw.read_ram_data_in;
      r_alu <= mw.alu_result_in;
    end
  end

  // Fill bit for a narrow load: its MSB when signed, otherwise zero.
  assign w_byte_fill = r_load_signed & r_ram[7];
  assign w_half_fill = r_load_signed & r_ram[HALF_W-1];

  // Extend the byte and half fields of the registered load data to DATA_W.
  always_comb begin
    w_byte_ext = '0;
    w_half_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_byte_ext[i] = (i < 8)      ? r_ram[i] : w_byte_fill;
      w_half_ext[i] = (i < HALF_W) ? r_ram[i] : w_half_fill;
    end
  end

  // Select the load view from the registered size field.
  always_comb begin
    w_load_data = r_ram;
    case (r_load_size)
      2'd0:    w_load_data = w_byte_ext;
      2'd1:    w_load_data = w_half_ext;
      default: w_load_data = r_ram;
    endcase
  end

  // Write-back source: load data or ALU result.
  always_comb begin
    w_wb_data = r_alu;
    if (r_mem_to_reg) begin
      w_wb_data = w_load_data;
    end
  end

  // Write enable, with optional suppression of writes to register 0.
  assign w_rd_suppressed = SUPPRESS_R0 && (r_rd == '0);
  assign w_wb_we         = r_valid & r_regwrite & ~w_rd_suppressed;

  assign mw.wb_valid = r_valid;
  assign mw.wb_rd    = r_rd;
  assign mw.wb_data  = w_wb_data;
  assign mw.wb_we    = w_wb_we;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  // Count each instruction once, on the edge where it leaves the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (r_valid && !mw.stall) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign mw.retire_count = r_retire_cnt;
`else
  // Without the counter, CNT_W only keeps the parameter list uniform.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// tb_memwb_stage: self-checking bench for memwb_stage.
// Two instances share one stimulus stream: an 8-bit stage with ZERO_REG=0 and
// a 16-bit stage with ZERO_REG=1. Expected values come from constant vector
// tables, hand-written sequences and an arithmetic reference model.
module tb_memwb_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memwb_stage_if #(.DATA_W(8),  .RADDR_W(3), .CNT_W(4)) if8 ();
  memwb_stage_if #(.DATA_W(16), .RADDR_W(3), .CNT_W(4)) if16 ();

  memwb_stage #(.DATA_W(8),  .RADDR_W(3), .ZERO_REG(0), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .mw(if8.slave));
  memwb_stage #(.DATA_W(16), .RADDR_W(3), .ZERO_REG(1), .CNT_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .mw(if16.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Current stimulus
  logic        s_v, s_rw, s_m2r, s_sg, s_st, s_fl;
  logic [1:0]  s_sz;
  logic [15:0] s_ram, s_alu;
  logic [2:0]  s_rd;

  // Reference model: contents of the stage plus the retire count
  logic        m_v, m_rw, m_m2r, m_sg;
  logic [1:0]  m_sz;
  logic [15:0] m_ram, m_alu;
  logic [2:0]  m_rd;
  int          m_cnt;

  typedef struct {
    logic v, rw, m2r;
    logic [1:0] sz;
    logic sg;
    logic [15:0] ram, alu;
    logic [2:0] rd;
    logic e_v, e_we8, e_we16;
    logic [7:0] e_d8;
    logic [15:0] e_d16;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                       input logic sg, input logic [15:0] ram, input logic [15:0] alu,
                       input logic [2:0] rd, input logic st, input logic fl);
    s_v = v; s_rw = rw; s_m2r = m2r; s_sz = sz; s_sg = sg;
    s_ram = ram; s_alu = alu; s_rd = rd; s_st = st; s_fl = fl;
    if8.valid_in = v;        if16.valid_in = v;
    if8.regwrite_in = rw;    if16.regwrite_in = rw;
    if8.mem_to_reg_in = m2r; if16.mem_to_reg_in = m2r;
    if8.load_size_in = sz;   if16.load_size_in = sz;
    if8.load_signed_in = sg; if16.load_signed_in = sg;
    if8.read_ram_data_in = ram[7:0]; if16.read_ram_data_in = ram;
    if8.alu_result_in = alu[7:0];    if16.alu_result_in = alu;
    if8.rd_in = rd;          if16.rd_in = rd;
    if8.stall = st;          if16.stall = st;
    if8.flush = fl;          if16.flush = fl;
  endtask

  function automatic void model_reset();
    m_v = 0; m_rw = 0; m_m2r = 0; m_sg = 0; m_sz = 0;
    m_ram = 0; m_alu = 0; m_rd = 0; m_cnt = 0;
  endfunction

  // One clock edge of the stage, stated as its rules.
  function automatic void model_edge();
    if (m_v && !s_st) m_cnt = (m_cnt + 1) % 16;
    if (s_fl || !s_st) begin
      m_v = s_fl ? 1'b0 : s_v;
      m_rw = s_fl ? 1'b0 : s_rw;
      m_m2r = s_m2r; m_sz = s_sz; m_sg = s_sg;
      m_ram = s_ram; m_alu = s_alu; m_rd = s_rd;
    end
  endfunction

  // Write-back value for a datapath of w bits, computed arithmetically.
  function automatic longint exp_data(input int w);
    longint full, narrow;
    int nb;
    full = longint'(1) << w;
    if (!m_m2r) return longint'(m_alu) % full;
    nb = (m_sz == 0) ? 8 : (m_sz == 1) ? ((w < 16) ? w : 16) : w;
    narrow = longint'(m_ram) % (longint'(1) << nb);
    if (m_sg && narrow >= (longint'(1) << (nb - 1)))
      narrow = narrow + full - (longint'(1) << nb);
    return narrow;
  endfunction

  task automatic check_model();
    chk("valid8", longint'(if8.wb_valid), longint'(m_v));
    chk("valid16", longint'(if16.wb_valid), longint'(m_v));
    chk("we8", longint'(if8.wb_we), longint'(m_v & m_rw));
    chk("we16", longint'(if16.wb_we), longint'(m_v & m_rw & (m_rd != 0)));
    if (m_v) begin
      chk("rd8", longint'(if8.wb_rd), longint'(m_rd));
      chk("rd16", longint'(if16.wb_rd), longint'(m_rd));
      chk("data8", longint'(if8.wb_data), exp_data(8));
      chk("data16", longint'(if16.wb_data), exp_data(16));
    end
`ifdef MEMWB_RETIRE_CNT_EN
    chk("cnt8", longint'(if8.retire_count), longint'(m_cnt));
    chk("cnt16", longint'(if16.retire_count), longint'(m_cnt));
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid8"}, longint'(if8.wb_valid), 0);
    chk({tag, "_we8"}, longint'(if8.wb_we), 0);
    chk({tag, "_rd8"}, longint'(if8.wb_rd), 0);
    chk({tag, "_data8"}, longint'(if8.wb_data), 0);
    chk({tag, "_valid16"}, longint'(if16.wb_valid), 0);
    chk({tag, "_we16"}, longint'(if16.wb_we), 0);
    chk({tag, "_data16"}, longint'(if16.wb_data), 0);
`ifdef MEMWB_RETIRE_CNT_EN
    chk({tag, "_cnt8"}, longint'(if8.retire_count), 0);
    chk({tag, "_cnt16"}, longint'(if16.retire_count), 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // v rw m2r sz sg ram alu rd | e_v e_we8 e_we16 e_d8 e_d16
    tbl[0]  = '{1,1,0,2'd0,0,16'h0000,16'h005A,3'd3, 1,1,1,8'h5A,16'h005A};
    tbl[1]  = '{1,1,1,2'd2,0,16'h12C3,16'h0000,3'd3, 1,1,1,8'hC3,16'h12C3};
    tbl[2]  = '{1,1,1,2'd0,1,16'h12F0,16'h0000,3'd4, 1,1,1,8'hF0,16'hFFF0};
    tbl[3]  = '{1,1,1,2'd0,0,16'h12F0,16'h0000,3'd4, 1,1,1,8'hF0,16'h00F0};
    tbl[4]  = '{1,1,1,2'd1,1,16'h12F0,16'h0000,3'd4, 1,1,1,8'hF0,16'h12F0};
    tbl[5]  = '{1,1,1,2'd1,1,16'h82F0,16'h0000,3'd4, 1,1,1,8'hF0,16'h82F0};
    tbl[6]  = '{1,1,0,2'd0,0,16'h0000,16'h0077,3'd0, 1,1,0,8'h77,16'h0077};
    tbl[7]  = '{0,1,0,2'd0,0,16'h0000,16'h0033,3'd2, 0,0,0,8'h33,16'h0033};
    tbl[8]  = '{1,0,0,2'd0,0,16'h0000,16'h0044,3'd1, 1,0,0,8'h44,16'h0044};
    tbl[9]  = '{1,1,1,2'd0,1,16'h0080,16'h0000,3'd7, 1,1,1,8'h80,16'hFF80};
    tbl[10] = '{1,1,1,2'd3,1,16'h8001,16'h0000,3'd7, 1,1,1,8'h01,16'h8001};
    tbl[11] = '{1,1,1,2'd1,0,16'h8001,16'h0000,3'd6, 1,1,1,8'h01,16'h8001};

    rst = 1'b1;
    model_reset();
    drive(0,0,0,0,0,0,0,0,0,0);
    #12 check_zero("init");
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].sz, tbl[i].sg,
            tbl[i].ram, tbl[i].alu, tbl[i].rd, 0, 0);
      tick();
      chk($sformatf("tbl%0d_valid", i), longint'(if16.wb_valid), longint'(tbl[i].e_v));
      chk($sformatf("tbl%0d_we8", i), longint'(if8.wb_we), longint'(tbl[i].e_we8));
      chk($sformatf("tbl%0d_we16", i), longint'(if16.wb_we), longint'(tbl[i].e_we16));
      chk($sformatf("tbl%0d_rd", i), longint'(if8.wb_rd), longint'(tbl[i].rd));
      chk($sformatf("tbl%0d_d8", i), longint'(if8.wb_data), longint'(tbl[i].e_d8));
      chk($sformatf("tbl%0d_d16", i), longint'(if16.wb_data), longint'(tbl[i].e_d16));
    end

    // Asynchronous reset while holding a valid instruction
    drive(1,1,0,0,0,16'h0000,16'h00A5,3'd5,0,0);
    tick();
    do_reset();

    // Stall holds the stage for three cycles, then flush+stall makes a bubble
    drive(1,1,0,0,0,16'h0000,16'h0011,3'd5,0,0);
    tick();
    drive(1,1,0,0,0,16'h0000,16'h0022,3'd6,1,0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_rd", longint'(if16.wb_rd), 5);
      chk("stall_data", longint'(if16.wb_data), 16'h0011);
      chk("stall_we", longint'(if8.wb_we), 1);
    end
    drive(1,1,0,0,0,16'h0000,16'h0022,3'd6,1,1);
    tick();
    chk("flush_valid", longint'(if8.wb_valid), 0);
    chk("flush_we", longint'(if16.wb_we), 0);
    drive(0,0,0,0,0,0,0,0,0,0);
    tick();

`ifdef MEMWB_RETIRE_CNT_EN
    // Three instructions with a two-cycle stall retire exactly three times
    do_reset();
    drive(1,1,0,0,0,0,16'h0001,3'd1,0,0); tick();
    drive(1,1,0,0,0,0,16'h0002,3'd2,0,0); tick();
    drive(1,1,0,0,0,0,16'h0003,3'd3,1,0); tick(); tick();
    drive(1,1,0,0,0,0,16'h0003,3'd3,0,0); tick();
    drive(0,0,0,0,0,0,0,0,0,0); tick(); tick();
    chk("cnt_three", longint'(if8.retire_count), 3);
    drive(1,1,0,0,0,0,16'h0009,3'd4,0,0);
    for (int k = 0; k < 13; k++) tick();
    chk("cnt_fifteen", longint'(if16.retire_count), 15);
    drive(0,0,0,0,0,0,0,0,0,0); tick();
    chk("cnt_wrap", longint'(if16.retire_count), 0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
# memwb_stage

Parametrised MEM/WB pipeline register for the RISC core, sitting between the memory stage and the register-file write port. It captures ALU result, load data, destination register and control on each clock. It adds stall (hold), flush (bubble insertion), a per-instruction valid bit and load-size/sign extension on the write-back path. It also exports a registered forwarding tap for the EX-stage bypass mux.

## Interface
Parameters:
- DATA_W, 8, datapath width; must be a multiple of 8, minimum 8.
- RADDR_W, 3, register-address width.
- ZERO_REG, 0, when 1, writes to register 0 are suppressed.
- CNT_W, 16, retire-counter width; used only with MEMWB_RETIRE_CNT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  incoming MEM-stage slot holds a real instruction.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble instead of the incoming instruction.
- regwrite_in  in  1  instruction writes the register file.
- mem_to_reg_in  in  1  write-back source: 1 = load data, 0 = ALU result.
- load_size_in  in  2  0 = byte, 1 = half, 2/3 = full width.
- load_signed_in  in  1  sign-extend the narrow load (otherwise zero-extend).
- read_ram_data_in  in  DATA_W  load data from data RAM.
- alu_result_in  in  DATA_W  ALU result.
- rd_in  in  RADDR_W  destination register.
- wb_we  out  1  register-file write enable.
- wb_rd  out  RADDR_W  register-file write address.
- wb_data  out  DATA_W  register-file write data.
- wb_valid  out  1  stage holds a valid instruction.
- retire_count  out  CNT_W  retired-instruction count; present only with MEMWB_RETIRE_CNT_EN.

## Operation
- State registers: valid_q, regwrite_q, mem_to_reg_q, load_size_q, load_signed_q, ram_q, alu_q, rd_q.
- Update priority on each rising edge, flush > stall > load:
  - flush=1: valid_q←0 and regwrite_q←0; data fields are don't-care (implementation loads them).
  - else stall=1: every register holds.
  - else: every register loads its input.
- wb_valid = valid_q.
- wb_rd = rd_q.
- wb_we = valid_q & regwrite_q & ~(ZERO_REG && rd_q==0).
- wb_data is combinational from registered fields only:
  - mem_to_reg_q=0: alu_q, unmodified.
  - mem_to_reg_q=1, size 0: ram_q[7:0] extended to DATA_W.
  - mem_to_reg_q=1, size 1: ram_q[min(16,DATA_W)-1:0] extended. When DATA_W=8 this equals full width.
  - mem_to_reg_q=1, size 2/3: ram_q unmodified.
  - Extension fills with the MSB of the narrow field when load_signed_q=1, otherwise with zeros.
- flush and stall together: flush wins; the stage becomes a bubble.
- The stage is also the forwarding tap. Consumers compare wb_rd against source registers and qualify the match with wb_we.

## Timing
- Latency: inputs captured on edge N appear on the outputs after edge N; one stage.
- Outputs are glitch-free with respect to inputs: no combinational input→output path.
- Reset (asynchronous assert, takes effect immediately without a clock edge): all registers 0.
  - Resulting outputs: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, retire_count=0.
- Reset deassertion: the first capture occurs on the first rising edge with rst=0.
- Reset mid-stall or mid-flush: reset dominates; the stall/flush state is not remembered.
- Stall for K cycles: outputs remain constant for K cycles. wb_we stays asserted; rewriting the same value is benign.

## Configuration
- MEMWB_RETIRE_CNT_EN defined:
  - Adds the CNT_W-bit retire_count register and port.
  - Increments by 1 on each edge where valid_q=1 and stall=0.
  - A stalled instruction therefore counts exactly once.
  - flush does not block counting of the instruction already in the stage.
  - Wraps from 2^CNT_W−1 to 0.
  - Reset to 0 asynchronously.
- Macro undefined: no counter logic and no retire_count port; all other behaviour is identical.

## Test plan
- Reset: assert rst asynchronously mid-cycle while holding valid data -> all outputs 0 immediately, before the next edge.
- Basic pass (DATA_W=8):
  - Stimulus: valid_in=1, regwrite_in=1, mem_to_reg_in=0, alu_result_in=0x5A, rd_in=3.
  - Response after one edge: wb_we=1, wb_rd=3, wb_data=0x5A.
  - Stimulus: mem_to_reg_in=1, read_ram_data_in=0xC3.
  - Response: wb_data=0xC3.
- Load extension (DATA_W=16, mem_to_reg_in=1, read_ram_data_in=0x12F0):
  - Byte, signed -> wb_data=0xFFF0.
  - Byte, unsigned -> 0x00F0.
  - Half -> 0x12F0.
- Stall/flush:
  - Stage holds rd=5, data 0x11; then stall=1 for 3 cycles with new inputs rd=6, data 0x22 -> outputs stay rd=5/0x11.
  - Then flush=1 and stall=1 together -> wb_valid=0, wb_we=0 after the edge.
- Zero register, ZERO_REG=1: valid regwrite to rd=0 -> wb_we=0, wb_valid=1. Same stimulus with ZERO_REG=0 -> wb_we=1.
- Retire counter, MEMWB_RETIRE_CNT_EN, CNT_W=4:
  - 3 valid instructions with one 2-cycle stall -> retire_count=3.
  - Starting from 15, one more retire -> 0.
